// File: rtl/qsys_epcs_ram_loader.sv
// -----------------------------------------------------------------------------
// qsys_epcs_ram_loader
//
// Boot-image loader that sits in front of a single-port on-chip RAM
// (DEPTH x 32, 13-bit word address, 4-bit byteenable). It takes a byte stream
// from the EPCS flash reader, packs four bytes little-endian into a 32-bit
// word and writes the words to consecutive RAM addresses starting at a
// programmed base. With VERIFY=1 every word is read back and compared before
// the next word is accepted.
//
// Ports
//   clk_i              system clock, all logic on the rising edge
//   reset_i            synchronous active-high reset
//   start_i            1-cycle start pulse, only honoured while idle
//   base_addr_i        first RAM word address
//   word_count_i       number of words to load (0..DEPTH)
//   s_data_i           flash byte data
//   s_valid_i          flash byte valid
//   s_ready_o          loader accepts a byte this cycle
//   ram_address_o      RAM word address (0 while no access)
//   ram_byteenable_o   4'hF during an access, 4'h0 otherwise
//   ram_chipselect_o   RAM access strobe
//   ram_write_o        RAM write strobe
//   ram_writedata_o    packed word (0 while no access)
//   ram_clken_o        RAM clock enable, tied high
//   ram_readdata_i     RAM read data, valid the cycle after the read access
//   busy_o             high in every state except IDLE
//   done_o             1-cycle pulse on successful completion
//   error_o            sticky range / verify failure flag
//   words_done_o       words written since the last accepted start
// -----------------------------------------------------------------------------
module qsys_epcs_ram_loader #(
    parameter int DEPTH  = 7680,
    parameter bit VERIFY = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [12:0] base_addr_i,
    input  logic [12:0] word_count_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [12:0] ram_address_o,
    output logic [3:0]  ram_byteenable_o,
    output logic        ram_chipselect_o,
    output logic        ram_write_o,
    output logic [31:0] ram_writedata_o,
    output logic        ram_clken_o,
    input  logic [31:0] ram_readdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [12:0] words_done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_READ,
        ST_CMP,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [13:0] DEPTH_W = 14'(DEPTH);

    state_e      state_q, state_d;
    logic [12:0] count_q, count_d;
    logic [12:0] addr_q, addr_d;
    logic [12:0] words_done_q, words_done_d;
    logic [1:0]  idx_q, idx_d;
    logic        error_q, error_d;
    logic [3:0]  lane_we;
    logic [31:0] packed_word;
    logic [13:0] range_sum;

    // Sum is one bit wider than the operands so base+count can never wrap
    // and slip under the range check.
    assign range_sum = {1'b0, base_addr_i} + {1'b0, word_count_i};

    // One byte register per lane; lane gi holds bits [8*gi+7:8*gi].
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] byte_q;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                byte_q <= '0;
            end else if (lane_we[gi]) begin
                byte_q <= s_data_i;
            end
        end

        assign packed_word[8*gi +: 8] = byte_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            addr_q       <= '0;
            words_done_q <= '0;
            idx_q        <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            words_done_q <= words_done_d;
            idx_q        <= idx_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        addr_d       = addr_q;
        words_done_d = words_done_q;
        idx_d        = idx_q;
        error_d      = error_q;
        lane_we      = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    count_d      = word_count_i;
                    addr_d       = base_addr_i;
                    words_done_d = '0;
                    idx_d        = '0;
                    error_d      = 1'b0;
                    if (range_sum > DEPTH_W) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else if (word_count_i == 13'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                if (s_valid_i) begin
                    lane_we[idx_q] = 1'b1;
                    idx_d          = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                words_done_d = words_done_q + 13'd1;
                if (VERIFY) begin
                    // Address is held so the read-back hits the same word.
                    state_d = ST_READ;
                end else begin
                    addr_d = addr_q + 13'd1;
                    if ((words_done_q + 13'd1) == count_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            ST_READ: begin
                state_d = ST_CMP;
            end

            ST_CMP: begin
                // words_done already counts the word being checked here.
                if (ram_readdata_i != packed_word) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    addr_d = addr_q + 13'd1;
                    if (words_done_q == count_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            ST_ERROR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_ready_o        = (state_q == ST_FILL);
    assign ram_chipselect_o = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign ram_write_o      = (state_q == ST_WRITE);
    assign ram_byteenable_o = ram_chipselect_o ? 4'hF : 4'h0;
    assign ram_address_o    = ram_chipselect_o ? addr_q : 13'd0;
    assign ram_writedata_o  = ram_chipselect_o ? packed_word : 32'd0;
    assign ram_clken_o      = 1'b1;
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = (state_q == ST_DONE);
    assign error_o          = error_q;
    assign words_done_o     = words_done_q;

endmodule

// File: tb/tb_qsys_epcs_ram_loader.sv
// -----------------------------------------------------------------------------
// Self-checking bench for qsys_epcs_ram_loader (VERIFY=1).
// A RAM model answers the slave port, a byte source feeds the stream, and the
// expected write sequence / outcome of every load is derived from the load
// request and the byte list alone.
// -----------------------------------------------------------------------------
module tb_qsys_epcs_ram_loader;

    localparam int DEPTH = 7680;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [12:0] word_count;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [12:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] words_done;

    always #5 clk = ~clk;

    qsys_epcs_ram_loader #(
        .DEPTH  (DEPTH),
        .VERIFY (1'b1)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_i          (start),
        .base_addr_i      (base_addr),
        .word_count_i     (word_count),
        .s_data_i         (s_data),
        .s_valid_i        (s_valid),
        .s_ready_o        (s_ready),
        .ram_address_o    (ram_address),
        .ram_byteenable_o (ram_byteenable),
        .ram_chipselect_o (ram_chipselect),
        .ram_write_o      (ram_write),
        .ram_writedata_o  (ram_writedata),
        .ram_clken_o      (ram_clken),
        .ram_readdata_i   (ram_readdata),
        .busy_o           (busy),
        .done_o           (done),
        .error_o          (error),
        .words_done_o     (words_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference state
    logic [31:0] mem [0:DEPTH-1];
    logic [7:0]  src_q [$];
    logic [12:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    int          n_writes, n_done, consumed;
    bit          err_seen;
    int          cyc = 0;
    int          start_cyc, err_cyc, done_cyc;
    int          pattern = 0;
    int          corrupt_addr = -1;
    bit          rd_pend = 1'b0;
    logic [12:0] rd_addr;
    bit          lat_pend = 1'b0;
    int          lat;
    bit          prev_done = 1'b0;
    bit          prev_write = 1'b0;
    logic [12:0] last_wr_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte source and RAM read-data driver, updated just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_pend) begin
                ram_readdata = mem[rd_addr] ^ ((int'(rd_addr) == corrupt_addr) ? 32'h1 : 32'h0);
                rd_pend = 1'b0;
            end else begin
                ram_readdata = $urandom;
            end
            if (src_q.size() > 0 &&
                (pattern == 0 || (pattern == 1 && (cyc % 2) == 0) ||
                 (pattern == 2 && $urandom_range(0, 9) < 7))) begin
                s_valid = 1'b1;
                s_data  = src_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end
        end
    end

    // Per-cycle compare process, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_done  = 1'b0;
                prev_write = 1'b0;
            end else begin
                chk("clken", 32'(ram_clken), 32'h1);
                chk("byteenable", 32'(ram_byteenable), ram_chipselect ? 32'hF : 32'h0);
                if (ram_write) chk("write_without_cs", 32'(ram_chipselect), 32'h1);
                if (s_ready) chk("ready_while_idle", 32'(busy), 32'h1);
                if (busy) chk("words_done", 32'(words_done), n_writes);
                if (done) begin
                    chk("done_twice", 32'(prev_done), 32'h0);
                    chk("done_with_error", 32'(error), 32'h0);
                    n_done++;
                    done_cyc = cyc;
                end
                if (busy && error && !err_seen) begin
                    err_seen = 1'b1;
                    err_cyc  = cyc;
                end
                if (ram_chipselect && ram_write) begin
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_write", 32'(exp_addr_q.size()), 32'h1);
                    end else begin
                        chk("wr_addr", 32'(ram_address), 32'(exp_addr_q.pop_front()));
                        chk("wr_data", ram_writedata, exp_data_q.pop_front());
                    end
                    if (ram_address < 13'(DEPTH)) mem[ram_address] = ram_writedata;
                    last_wr_addr = ram_address;
                    n_writes++;
                end
                if (ram_chipselect && !ram_write) begin
                    chk("rd_after_wr", 32'(prev_write), 32'h1);
                    chk("rd_addr", 32'(ram_address), 32'(last_wr_addr));
                    rd_pend = 1'b1;
                    rd_addr = ram_address;
                end
                // 4th byte accepted -> next ready 4 cycles later with read-back
                if (lat_pend) begin
                    lat++;
                    if (s_ready) begin
                        chk("word_latency", lat, 4);
                        lat_pend = 1'b0;
                    end
                end
                if (s_valid && s_ready) begin
                    if (src_q.size() == 0) chk("byte_underflow", 32'(src_q.size()), 32'h1);
                    else void'(src_q.pop_front());
                    consumed++;
                    if (consumed % 4 == 0) begin
                        lat_pend = 1'b1;
                        lat      = 0;
                    end
                end
                prev_done  = done;
                prev_write = ram_chipselect && ram_write;
            end
        end
    end

    // One load transaction. first_byte < 0 gives random bytes; corrupt_idx
    // selects a word whose read-back is flipped; reset_after >= 0 pulses reset
    // once that many bytes have been taken.
    task automatic run_load(input int base, input int cnt, input int pat, input int first_byte,
                            input int corrupt_idx, input bit mid_start, input int reset_after);
        logic [7:0]  b;
        logic [31:0] w;
        bit          range_ok = (base + cnt) <= DEPTH;
        bit          corrupt  = range_ok && corrupt_idx >= 0 && corrupt_idx < cnt;
        int          exp_writes, exp_bytes, exp_wd;
        bit          exp_done, exp_err;
        int          bound = 40 * cnt + 20;

        if (!range_ok) begin
            exp_writes = 0; exp_done = 0; exp_err = 1;
        end else if (reset_after >= 0) begin
            exp_writes = reset_after / 4; exp_done = 0; exp_err = 0;
        end else if (corrupt) begin
            exp_writes = corrupt_idx + 1; exp_done = 0; exp_err = 1;
        end else begin
            exp_writes = cnt; exp_done = 1; exp_err = 0;
        end
        exp_bytes = (reset_after >= 0 && range_ok) ? reset_after : 4 * exp_writes;
        exp_wd    = (reset_after >= 0) ? 0 : exp_writes;

        src_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        corrupt_addr = corrupt ? base + corrupt_idx : -1;
        for (int k = 0; k < cnt; k++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                b = (first_byte >= 0) ? 8'(first_byte + 4 * k + j) : 8'($urandom);
                src_q.push_back(b);
                w[8*j +: 8] = b;
            end
            if (k < exp_writes) begin
                exp_addr_q.push_back(13'(base + k));
                exp_data_q.push_back(w);
            end
        end
        for (int j = 0; j < 4; j++) src_q.push_back(8'($urandom));

        n_writes = 0; n_done = 0; consumed = 0; err_seen = 1'b0; lat_pend = 1'b0;
        pattern  = pat;

        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = 13'(base);
        word_count = 13'(cnt);
        start_cyc  = cyc;
        @(posedge clk); #1;
        start = 1'b0;

        if (reset_after >= 0) begin
            for (int i = 0; i < bound && consumed < reset_after; i++) begin
                @(posedge clk); #1;
            end
            chk("reach_bytes", consumed, reset_after);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end else begin
            for (int i = 0; i < bound && n_done == 0 && !err_seen; i++) begin
                if (mid_start && i == 10) begin
                    start      = 1'b1;
                    base_addr  = 13'd0;
                    word_count = 13'd1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
            end
            start = 1'b0;
            chk("timeout", 32'(n_done > 0 || err_seen), 32'h1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("busy_end", 32'(busy), 32'h0);
        chk("done_count", n_done, 32'(exp_done));
        chk("error_seen", 32'(err_seen), 32'(exp_err));
        chk("error_sticky", 32'(error), 32'(exp_err));
        chk("writes", n_writes, exp_writes);
        chk("bytes_consumed", consumed, exp_bytes);
        chk("exp_left", exp_addr_q.size(), 0);
        chk("words_done_end", 32'(words_done), exp_wd);
        if (!range_ok) chk("range_err_latency", 32'((err_cyc - start_cyc) <= 2), 32'h1);
        if (range_ok && cnt == 0) chk("zero_done_latency", done_cyc - start_cyc, 1);
        $display("load base=%0d count=%0d pat=%0d corrupt=%0d rst_after=%0d writes=%0d done=%0d err=%0d",
                 base, cnt, pat, corrupt_idx, reset_after, n_writes, n_done, err_seen);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int r_base, r_cnt, r_cor;

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        s_valid = 1'b0; s_data = '0; ram_readdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'h0);
        chk("rst_cs", 32'(ram_chipselect), 32'h0);
        chk("rst_write", 32'(ram_write), 32'h0);
        chk("rst_be", 32'(ram_byteenable), 32'h0);
        chk("rst_addr", 32'(ram_address), 32'h0);
        chk("rst_wdata", ram_writedata, 32'h0);
        chk("rst_clken", 32'(ram_clken), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_words_done", 32'(words_done), 32'h0);

        // Bytes 01..08 back-to-back into words 0 and 1.
        run_load(0, 2, 0, 1, -1, 1'b0, -1);
        chk("lit_word0", mem[0], 32'h04030201);
        chk("lit_word1", mem[1], 32'h08070605);

        // Out of range: 7678 + 3 > 7680.
        run_load(7678, 3, 0, -1, -1, 1'b0, -1);

        // Zero-length load.
        run_load(50, 0, 0, -1, -1, 1'b0, -1);

        // Read-back of word 1 of 3 corrupted.
        run_load(10, 3, 0, -1, 1, 1'b0, -1);

        // Toggling valid, plus an ignored start while busy.
        run_load(100, 4, 1, 16, -1, 1'b1, -1);
        chk("lit_word100", mem[100], 32'h13121110);
        chk("lit_word103", mem[103], 32'h1F1E1D1C);

        // Reset after 6 bytes, then a clean reload from byte lane 0.
        run_load(200, 4, 0, -1, -1, 1'b0, 6);
        run_load(200, 2, 0, 8'h40, -1, 1'b0, -1);
        chk("lit_word200", mem[200], 32'h43424140);
        chk("lit_word201", mem[201], 32'h47464544);

        // Range boundaries: exactly DEPTH allowed, one beyond rejected.
        run_load(7678, 2, 2, -1, -1, 1'b0, -1);
        run_load(1, 7680, 0, -1, -1, 1'b0, -1);

        for (int t = 0; t < 10; t++) begin
            r_cnt = $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) r_base = DEPTH - r_cnt + $urandom_range(0, 2);
            else r_base = $urandom_range(0, DEPTH - 8);
            r_cor = (r_cnt > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, r_cnt - 1) : -1;
            run_load(r_base, r_cnt, $urandom_range(0, 2), -1, r_cor, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
